// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch conditions,
// multiply/divide operations and the multiply/divide sequencer state type.
// The branch and M-op codes follow the RISC-V funct3 values so decode can
// pass them straight through.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_type_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // Operand A is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Operand B is treated as signed by MULH, DIV and REM.
  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request (already qualified with valid and not-flush)
//   flush         abort any operation in flight, discard result
//   op, a, b      M-op and operands, captured on the starting edge
//   busy          stall request: starting this cycle or iterating
//   done          result valid this cycle
//   result        signed-corrected result, meaningful when done
//
// state   | meaning
// --------+--------------------------------------------------------
// MD_IDLE | waiting for start
// MD_BUSY | one shift-add / restoring-divide step per cycle
// MD_DONE | result presented for exactly one cycle
module md_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // acc: product high half / partial remainder
  // lo:  multiplier shifting out, product low half shifting in / dividend -> quotient
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [2:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            bz_q, bz_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign a_neg = md_a_signed(op) & a[XLEN-1];
  assign b_neg = md_b_signed(op) & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : {XLEN{1'b0}})};
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(XLEN);
          acc_d   = '0;
          lo_d    = a_mag;
          opb_d   = b_mag;
          op_d    = op;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bz_d    = (b == '0);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q[2]) begin
          // Restoring divide: keep the trial subtraction only if it did not borrow.
          if (!div_trial[XLEN]) begin
            acc_d = div_trial[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
    end
  end

  // Sign correction on the magnitude result. A zero divisor leaves all-ones in
  // the quotient and |a| in the remainder; only the remainder gets the sign back.
  assign prod     = {acc_q, lo_q};
  assign prod_fix = qneg_q ? -prod : prod;
  assign quo_fix  = bz_q ? {XLEN{1'b1}} : (qneg_q ? -lo_q : lo_q);
  assign rem_fix  = rneg_q ? -acc_q : acc_q;

  always_comb begin
    result = '0;
    case (op_q)
      MD_MUL:                       result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_fix;
      MD_REM, MD_REMU:              result = rem_fix;
      default:                      result = '0;
    endcase
  end

  // Reset overrides everything: no stall and no result while rst is high.
  assign busy = ~rst & (((state_q == MD_IDLE) & start) | (state_q == MD_BUSY));
  assign done = ~rst & ~flush & (state_q == MD_DONE);

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand forwarding, ALU, branch resolution and an
// optional iterative multiply/divide unit that stalls the front of the pipe.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   validE, FlushE                E instruction valid / kill
//   ALUControlE, MdReqE, MdOpE    ALU op, M-op request and op
//   RD1E, RD2E, ResultW,
//   ALUResultM, PCE, ImmExtE      operands, forwarding sources, PC, immediate
//   ForwardA, ForwardB            forwarding selects
//   ALUsrcE, BranchE, JumpE,
//   BranchTypeE                   immediate select, branch/jump control
//   PCsrcE, PCTargetE             redirect and target
//   ALUResultE, WriteDataE        result, forwarded store data
//   StallE                        hold F/D/E while an M-op is pending
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validE,
  input  logic            FlushE,
  input  logic [3:0]      ALUControlE,
  input  logic            MdReqE,
  input  logic [2:0]      MdOpE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic            ALUsrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [2:0]      BranchTypeE,
  output logic            PCsrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic            StallE
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, src_b, alu_res, md_result;
  logic [SHW-1:0]  shamt;
  logic            br_taken, md_start, md_busy, md_done;

  always_comb begin
    case (ForwardA)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardB)
      FWD_W:   WriteDataE = ResultW;
      FWD_M:   WriteDataE = ALUResultM;
      default: WriteDataE = RD2E;
    endcase
  end

  assign src_b = ALUsrcE ? ImmExtE : WriteDataE;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (BranchTypeE)
      BR_BEQ:  br_taken = (src_a == src_b);
      BR_BNE:  br_taken = (src_a != src_b);
      BR_BLT:  br_taken = ($signed(src_a) < $signed(src_b));
      BR_BGE:  br_taken = ($signed(src_a) >= $signed(src_b));
      BR_BLTU: br_taken = (src_a < src_b);
      BR_BGEU: br_taken = (src_a >= src_b);
      default: br_taken = 1'b0;
    endcase
  end

  assign PCsrcE    = validE & ~FlushE & (JumpE | (BranchE & br_taken));
  assign PCTargetE = PCE + ImmExtE;
  assign md_start  = validE & MdReqE & ~FlushE;

  generate
    if (MD_EN != 0) begin : g_md
      md_unit #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .flush  (FlushE),
        .op     (MdOpE),
        .a      (src_a),
        .b      (src_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  assign StallE     = md_busy;
  assign ALUResultE = md_done ? md_result : alu_res;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        validE, FlushE, MdReqE, ALUsrcE, BranchE, JumpE;
  logic [3:0]  ALUControlE;
  logic [2:0]  MdOpE, BranchTypeE;
  logic [31:0] RD1E, RD2E, ResultW, ALUResultM, PCE, ImmExtE;
  logic [1:0]  ForwardA, ForwardB;
  logic        PCsrcE, StallE;
  logic [31:0] PCTargetE, ALUResultE, WriteDataE;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .MD_EN(1)) dut (
    .clk(clk), .rst(rst), .validE(validE), .FlushE(FlushE),
    .ALUControlE(ALUControlE), .MdReqE(MdReqE), .MdOpE(MdOpE),
    .RD1E(RD1E), .RD2E(RD2E), .ResultW(ResultW), .ALUResultM(ALUResultM),
    .PCE(PCE), .ImmExtE(ImmExtE), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .ALUsrcE(ALUsrcE), .BranchE(BranchE), .JumpE(JumpE), .BranchTypeE(BranchTypeE),
    .PCsrcE(PCsrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .StallE(StallE)
  );

  // An M-op request together with a branch or jump is illegal stimulus.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_asserts++;
      assert (!(validE && MdReqE && (JumpE || BranchE))) else begin
        n_fail++;
        $error("FAIL illegal_md_ctrl observed=1 expected=0");
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r, w, m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
    longint sa;
    int     sh;
    sa = longint'($signed(a));
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return 32'(longint'(a) * (64'd1 << sh));
      4'd8: return 32'(longint'({32'b0, a}) / (64'd1 << sh));
      4'd9: return 32'(sa >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] t, input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (t)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [2:0] bt_pick(input int k);
    case (k)
      0: return BR_BEQ;
      1: return BR_BNE;
      2: return BR_BLT;
      3: return BR_BGE;
      4: return BR_BLTU;
      default: return BR_BGEU;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    validE = 0; FlushE = 0; MdReqE = 0; BranchE = 0; JumpE = 0;
    ForwardA = 2'b00; ForwardB = 2'b00; ALUsrcE = 0;
    ALUControlE = ALU_ADD; BranchTypeE = BR_BEQ; MdOpE = MD_MUL;
  endtask

  // Issues an M-op in the current cycle and follows it to its result.
  // With hold the request stays on the inputs (as a stalled pipe would);
  // otherwise the inputs are scrambled while the unit iterates.
  task automatic md_op(input logic [2:0] op, input logic [31:0] a, b, input bit hold,
                       input string tag);
    logic [31:0] exp;
    int cnt;
    bit fin;
    exp = md_ref(op, a, b);
    clear_ctrl();
    validE = 1; MdReqE = 1; MdOpE = op; RD1E = a; RD2E = b;
    #4;
    chk({tag, "_req_stall"}, {31'b0, StallE}, 32'd1);
    cnt = 0;
    fin = 0;
    while (!fin && cnt < 100) begin
      tick();
      cnt++;
      if (!hold) begin
        validE = 1'($urandom); MdReqE = 1'($urandom); MdOpE = 3'($urandom);
        RD1E = $urandom; RD2E = $urandom; ImmExtE = $urandom;
        ALUsrcE = 1'($urandom); ForwardA = 2'($urandom); ALUResultM = $urandom;
      end
      #4;
      if (StallE !== 1'b1) fin = 1;
    end
    chk({tag, "_latency"}, cnt, 32'd33);
    chk({tag, "_result"}, ALUResultE, exp);
  endtask

  task automatic quiet_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      #4;
      chk({tag, "_stall"}, {31'b0, StallE}, 32'd0);
      chk({tag, "_alu"}, ALUResultE, RD1E + RD2E);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b, wd;
    logic        exp_pc;
    logic [3:0]  aop;
    logic [2:0]  mop;

    rst = 1; clear_ctrl();
    RD1E = 3; RD2E = 4; ResultW = 0; ALUResultM = 0; PCE = 0; ImmExtE = 0;
    tick();
    validE = 1; MdReqE = 1;
    #4;
    chk("rst_stall", {31'b0, StallE}, 32'd0);
    chk("rst_alu_comb", ALUResultE, 32'd7);
    tick();
    PCE = 32'h100; ImmExtE = 32'h40;
    #4;
    chk("rst_stall2", {31'b0, StallE}, 32'd0);
    chk("rst_pctarget", PCTargetE, 32'h140);
    tick();
    rst = 0; clear_ctrl();
    #4;
    chk("post_rst_stall", {31'b0, StallE}, 32'd0);

    // Forwarded ADD
    tick(); clear_ctrl();
    validE = 1; ForwardA = 2'b10; ALUResultM = 5; RD1E = 99; RD2E = 7;
    #4;
    chk("fwd_add", ALUResultE, 32'd12);
    chk("fwd_add_stall", {31'b0, StallE}, 32'd0);

    // BLT vs BLTU on the same operands
    tick(); clear_ctrl();
    validE = 1; BranchE = 1; BranchTypeE = BR_BLT; RD1E = 32'hFFFF_FFFF; RD2E = 1;
    PCE = 32'h0000_1000; ImmExtE = 32'h0000_0020;
    #4;
    chk("blt_taken", {31'b0, PCsrcE}, 32'd1);
    chk("blt_target", PCTargetE, 32'h0000_1020);
    tick();
    BranchTypeE = BR_BLTU;
    #4;
    chk("bltu_not_taken", {31'b0, PCsrcE}, 32'd0);
    tick();
    BranchTypeE = BR_BLT; FlushE = 1;
    #4;
    chk("blt_flushed", {31'b0, PCsrcE}, 32'd0);

    // Random combinational path
    for (int i = 0; i < 80; i++) begin
      tick(); clear_ctrl();
      aop = 4'($urandom_range(0, 9));
      ALUControlE = aop;
      RD1E = pick_operand(); RD2E = pick_operand(); ImmExtE = pick_operand();
      ResultW = $urandom; ALUResultM = $urandom; PCE = $urandom;
      ForwardA = 2'($urandom); ForwardB = 2'($urandom);
      ALUsrcE = 1'($urandom); BranchE = 1'($urandom); JumpE = ($urandom_range(0, 3) == 0);
      BranchTypeE = bt_pick($urandom_range(0, 5));
      validE = ($urandom_range(0, 4) != 0); FlushE = ($urandom_range(0, 4) == 0);
      #4;
      a = fwd(ForwardA, RD1E, ResultW, ALUResultM);
      wd = fwd(ForwardB, RD2E, ResultW, ALUResultM);
      b = ALUsrcE ? ImmExtE : wd;
      exp_pc = validE & ~FlushE & (JumpE | (BranchE & br_ref(BranchTypeE, a, b)));
      chk("rand_alu", ALUResultE, alu_ref(aop, a, b));
      chk("rand_wdata", WriteDataE, wd);
      chk("rand_pcsrc", {31'b0, PCsrcE}, {31'b0, exp_pc});
      chk("rand_target", PCTargetE, PCE + ImmExtE);
      chk("rand_stall", {31'b0, StallE}, 32'd0);
    end

    // Directed multiply/divide
    tick(); md_op(MD_MUL,  32'd7, 32'd6, 1'b1, "mul_7x6");
    tick(); md_op(MD_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
    tick(); md_op(MD_DIV,  32'd7, 32'd0, 1'b0, "div_by0");
    tick(); md_op(MD_REM,  32'd7, 32'd0, 1'b0, "rem_by0");
    tick(); md_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    tick(); md_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    tick(); md_op(MD_DIV,  32'hFFFF_FFF9, 32'd0, 1'b0, "div_neg_by0");
    tick(); md_op(MD_REM,  32'hFFFF_FFF9, 32'd2, 1'b0, "rem_neg");

    // Back-to-back: second request sits on the inputs the cycle after DONE
    tick(); md_op(MD_MUL, 32'h0001_2345, 32'h0000_6789, 1'b1, "b2b_mul");
    tick(); md_op(MD_DIV, 32'hFFFF_F000, 32'd7, 1'b1, "b2b_div");

    // Random multiply/divide
    for (int i = 0; i < 14; i++) begin
      mop = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      tick(); md_op(mop, a, b, 1'b0, "rand_md");
    end

    // Flush during BUSY
    tick(); clear_ctrl();
    validE = 1; MdReqE = 1; MdOpE = MD_DIVU; RD1E = 1000; RD2E = 7;
    #4;
    chk("flush_req_stall", {31'b0, StallE}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      validE = 0; MdReqE = 0;
      if (i == 10) FlushE = 1;
      #4;
      chk("flush_busy_stall", {31'b0, StallE}, 32'd1);
    end
    tick(); clear_ctrl();
    RD1E = 11; RD2E = 22;
    #4;
    chk("flush_stall_drop", {31'b0, StallE}, 32'd0);
    quiet_cycles(40, "flush_idle");

    // Reset mid-operation
    tick(); clear_ctrl();
    validE = 1; MdReqE = 1; MdOpE = MD_REMU; RD1E = 12345; RD2E = 100;
    #4;
    chk("rstop_req_stall", {31'b0, StallE}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      validE = 0; MdReqE = 0;
      #4;
    end
    tick();
    rst = 1;
    #4;
    chk("rstop_stall_in_rst", {31'b0, StallE}, 32'd0);
    tick(); clear_ctrl();
    rst = 0; RD1E = 5; RD2E = 9;
    #4;
    chk("rstop_stall_after", {31'b0, StallE}, 32'd0);
    quiet_cycles(40, "rstop_idle");

    // Unit still usable after abort
    tick(); md_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_after_rst");
    tick(); md_op(MD_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mulhsu");

    tick(); clear_ctrl();
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
